// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline sequencing controller: scoreboard entry,
// forwarding select encoding and controller state constants.
package pipe_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef logic [1:0] hz_state_t;
  localparam hz_state_t ST_RUN      = 2'd0;
  localparam hz_state_t ST_LD_STALL = 2'd1;
  localparam hz_state_t ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } sb_entry_t;

  // Youngest producer wins: the instruction now in EX lands in EX/MEM next cycle.
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder/pipeline-side bundle for hazard_ctrl: ID decode fields and EX/MEM status in,
// pipeline-register enables, flushes, forwarding selects and perf counters out.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_we;
  logic             id_is_load;
  logic             ex_brn_tkn;
  logic             dmem_req;
  logic             dmem_rdy;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
           ex_brn_tkn, dmem_req, dmem_rdy,
    input  pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
           ex_brn_tkn, dmem_req, dmem_rdy,
    output pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hz_match.sv
// One source-vs-scoreboard-entry comparator; x0 and non-writing entries never match.
module hz_match
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] idx,
  input  logic             use_src,
  input  sb_entry_t        ent,
  output logic             hit,
  output logic             ld_hit
);
  assign hit    = use_src & ent.v & ent.we & (ent.rd != '0) & (ent.rd == idx);
  assign ld_hit = hit & ent.ld;
endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: EX/MEM/WB scoreboard, load-use stalls, branch flushes,
// dmem wait freezes. Define HAZARD_FWD_EN for operand forwarding; otherwise RAW stalls.
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  hazard_ctrl_if.slave bus
);
  import pipe_pkg::*;

  hz_state_t             state, state_nxt;
  sb_entry_t             sb_ex, sb_mem, sb_wb;
  sb_entry_t [1:0]       stg;
  logic [1:0][REG_W-1:0] src_idx;
  logic [1:0]            src_use;
  logic [1:0][1:0]       hit, ld_hit;
  logic                  hold, redir, lu_cond, load_use;
  logic                  pc_we, ifid_flush, idex_flush;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;
  logic                  unused_hz;

  assign src_idx = {bus.id_rs2, bus.id_rs1};
  assign src_use = {bus.id_use_rs2, bus.id_use_rs1};
  assign stg     = {sb_mem, sb_ex};

  // hit[stage][src]: stage 0 = EX, 1 = MEM; src 0 = rs1, 1 = rs2
  for (genvar s = 0; s < 2; s++) begin : g_stg
    for (genvar r = 0; r < 2; r++) begin : g_src
      hz_match u_match (
        .idx     (src_idx[r]),
        .use_src (src_use[r]),
        .ent     (stg[s]),
        .hit     (hit[s][r]),
        .ld_hit  (ld_hit[s][r])
      );
    end
  end

  // WB needs no check: the regfile writes through to the ID read.
  assign unused_hz = ^{sb_wb, ld_hit};

  always_comb begin
    hold = bus.dmem_req & ~bus.dmem_rdy;
    if (state == ST_MEM_WAIT) hold = ~bus.dmem_rdy;
  end

`ifdef HAZARD_FWD_EN
  assign lu_cond = |ld_hit[0];
`else
  assign lu_cond = |hit;
`endif

  // A pending redirect kills the ID instruction, so its load-use is moot.
  assign redir      = bus.ex_brn_tkn & ~hold;
  assign load_use   = lu_cond & ~hold & ~bus.ex_brn_tkn;
  assign pc_we      = ~hold & ~load_use;
  assign ifid_flush = redir;
  assign idex_flush = redir | load_use;

  assign bus.pc_we      = pc_we;
  assign bus.ifid_we    = pc_we;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.pipe_hold  = hold;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;

  always_comb begin
    state_nxt = ST_RUN;
    if (hold)          state_nxt = ST_MEM_WAIT;
    else if (load_use) state_nxt = ST_LD_STALL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!hold) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= idex_flush ? '0 : sb_entry_t'{v: bus.id_valid, rd: bus.id_rd,
                                               we: bus.id_we, ld: bus.id_is_load};
    end
  end

`ifdef HAZARD_FWD_EN
  fwd_sel_t fwd_a, fwd_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!hold) begin
      fwd_a <= idex_flush ? FWD_RF : fwd_pick(hit[0][0], hit[1][0]);
      fwd_b <= idex_flush ? FWD_RF : fwd_pick(hit[0][1], hit[1][1]);
    end
  end

  assign bus.fwd_a_sel = fwd_a;
  assign bus.fwd_b_sel = fwd_b;
`else
  assign bus.fwd_a_sel = FWD_RF;
  assign bus.fwd_b_sel = FWD_RF;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we)              stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && pc_we) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the five-stage RV32I core.
- Keeps a scoreboard of destination registers for the instructions in EX, MEM and WB.
- From that scoreboard and the ID-stage decode fields it produces registered forwarding selects, load-use stalls, branch flushes and data-memory wait freezes.
- Sits beside the decoder, consumes its rs1/rs2/rd/opcode-derived flags and the EX-stage branch-taken result, and drives every pipeline-register enable and flush.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- REG_W, 5, register index width.

Ports:
- clock  in  1  core clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_W  ID source 1 index.
- id_rs2  in  REG_W  ID source 2 index.
- id_use_rs1  in  1  instruction reads rs1 (0 for U/J types).
- id_use_rs2  in  1  instruction reads rs2 (R/S/B only).
- id_rd  in  REG_W  ID destination index.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- ex_brn_tkn  in  1  branch or jump in EX redirects the PC.
- dmem_req  in  1  MEM stage has an outstanding load/store.
- dmem_rdy  in  1  data memory completes this cycle.
- pc_we  out  1  PC register enable.
- ifid_we  out  1  IF/ID register enable.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_b_sel  out  2  EX operand B source, same encoding.
- stall_cnt  out  CNT_W  cycles with pc_we=0.
- flush_cnt  out  CNT_W  redirects taken.

Behaviour:
- Reset (async, reset_n=0):
  - All scoreboard entries invalid; state RUN.
  - fwd_*_sel=00; counters 0.
  - Combinational outputs evaluate from reset state: pc_we=1, ifid_we=1, flush and hold outputs 0.
- Scoreboard: three entries EX, MEM, WB, each {v, rd, we, ld}.
  - On advance (pipe_hold=0): WB<=MEM, MEM<=EX.
  - EX<={id_valid, id_rd, id_we, id_is_load} unless idex_flush=1, in which case EX<=invalid.
  - A source matches an entry only if v & we & rd!=0 & use bit set.
- FSM states: RUN, LD_STALL, MEM_WAIT.
  - RUN -> MEM_WAIT when dmem_req & ~dmem_rdy.
  - RUN -> LD_STALL on load-use: an ID source matches EX with ld=1, and no redirect this cycle.
  - LD_STALL -> RUN after exactly one cycle. The bubble is now in EX and the load is in MEM, so the source forwards from MEM/WB.
  - MEM_WAIT -> RUN in the cycle dmem_rdy=1. The pipeline advances in that same cycle.
- Outputs (combinational from state and inputs):
  - MEM_WAIT, or entering it: pipe_hold=1, pc_we=0, ifid_we=0, no flushes.
  - Load-use: pc_we=0, ifid_we=0, idex_flush=1.
  - ex_brn_tkn & ~hold: ifid_flush=1, idex_flush=1, pc_we=1.
- Priority: memory wait > branch redirect > load-use.
  - A redirect during MEM_WAIT is held, because EX is frozen and ex_brn_tkn persists, and acts on release.
  - A load-use coinciding with a redirect is discarded.
- Forwarding selects are registered and update on advance, so they are valid while the instruction occupies EX.
  - Per source: a match against the current EX entry gives 01.
  - Else a match against the current MEM entry gives 10.
  - Else 00.
  - Youngest producer wins.
  - WB-stage producers need no forwarding; the regfile writes through.
  - On idex_flush the selects clear to 00.
  - While held, the selects keep their value.
- Counters:
  - stall_cnt increments each cycle pc_we=0.
  - flush_cnt increments each cycle ifid_flush=1 & pc_we=1.
  - Both wrap modulo 2^CNT_W.
- Reset mid-stall returns to RUN with an empty scoreboard immediately.

Optional Feature:
- HAZARD_FWD_EN defined: forwarding as above.
- Undefined:
  - fwd_*_sel is tied to 00.
  - Any ID source matching a valid EX or MEM entry (load or not) stalls with the load-use actions, and stays in LD_STALL until no match remains.
  - A WB match needs no stall.

Decomposition:
- Package pipe_pkg: fwd_sel_t (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10), hz_state_t, sb_entry_t struct, REG_W constant.
- One sub-module, hz_match: compares a source {idx, use} against an sb_entry_t and outputs hit. Instantiated four times (2 sources x EX/MEM).

Test Plan:
- add x5,x1,x2 then add x6,x5,x3 -> no stall; fwd_a_sel=01 in the second instruction's EX cycle.
- lw x5,0(x1) then add x6,x0,x5 -> one cycle pc_we=0 with idex_flush=1, then fwd_b_sel=10; stall_cnt=1.
- beq taken in EX with ex_brn_tkn=1 -> ifid_flush=idex_flush=1 for one cycle; flush_cnt=1; the following EX entry is invalid.
- dmem_req=1, dmem_rdy=0 for 3 cycles while ex_brn_tkn=1 -> pipe_hold=1 for 3 cycles, then the flush fires on the release cycle; stall_cnt=3.
- Write to x0 followed by a read of x0 -> no forwarding and no stall.
- reset_n pulsed low during LD_STALL -> outputs return to reset values asynchronously and the scoreboard empties. With HAZARD_FWD_EN undefined, the case-1 pair stalls 2 cycles.
